// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and default sizes for the data-memory dump arbiter.
//   arb_state_t : arbiter FSM states
//   DEF_N       : default data word width
//   DEF_AW      : default word-address width
//   DEF_DEPTH   : default number of words walked per dump
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int DEF_N     = 64;
  localparam int DEF_AW    = 6;
  localparam int DEF_DEPTH = 64;

  // IDLE  : processor owns the memory port
  // READ  : one-cycle read of the word at the current walk index
  // SEND  : captured word is offered on the stream until accepted
  // DONE  : one-cycle completion pulse before handing the port back
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // True when the walk index has reached the final word of the dump.
  function automatic logic is_last_word(input logic [DEF_AW-1:0] idx,
                                        input logic [DEF_AW-1:0] last_idx);
    return (idx == last_idx);
  endfunction

endpackage

// File: rtl/dmem_dump_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_dump_arbiter_if
// Dump stream bundle between the arbiter (master) and the word consumer
// (slave).
//   dump_valid : dump_data/dump_addr hold a valid word
//   dump_ready : consumer accepts the word this cycle
//   dump_addr  : word index being streamed
//   dump_data  : streamed word
//   dump_busy  : arbiter owns the memory port (any state but IDLE)
//   dump_done  : one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
interface dmem_dump_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int AW = DEF_AW
);

  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [N-1:0]  dump_data;
  logic          dump_busy;
  logic          dump_done;

  modport master (
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_busy,
    output dump_done,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_busy,
    input  dump_done,
    output dump_ready
  );

endinterface

// File: rtl/dmem_dump_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_dump_arbiter
// Shares the single data-memory port between the processor and a memory-dump
// streamer. A rising edge on dump_req stalls the processor, walks every word
// 0..DEPTH-1 (one read cycle + one send cycle per word) and streams each word
// out over a valid/ready handshake, then returns the port to the processor.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cpu_addr/wdata/we/re, cpu_rdata : processor side of the memory port
//   cpu_stall         : datapath must freeze while high
//   mem_addr/wdata/we/re, mem_rdata : dmem side (combinational read)
//   dump_req          : level request, only a rising edge starts a dump
//   dump_if (master)  : dump stream + busy/done status
// -----------------------------------------------------------------------------
module dmem_dump_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  // processor side
  input  logic [AW-1:0] cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_re,
  output logic [N-1:0]  cpu_rdata,
  output logic          cpu_stall,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [N-1:0]  mem_rdata,
  // dump control and stream
  input  logic          dump_req,
  dmem_dump_arbiter_if.master dump_if
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] IDX_ZERO = {AW{1'b0}};

  arb_state_t    state_r;
  logic [AW-1:0] idx_r;
  logic          req_q_r;
  logic          pending_r;
  logic [N-1:0]  dump_data_r;
  logic [AW-1:0] dump_addr_r;
  logic          valid_r;
  logic          busy_r;
  logic          done_r;
  logic          req_rise_s;
  logic          last_word_s;

  // Rising-edge detect on the level request.
  assign req_rise_s = dump_req & ~req_q_r;

  // Terminal compare on the walk index; checked before any increment so the
  // index never steps past DEPTH-1.
  assign last_word_s = (idx_r == LAST_IDX);

  // Arbiter FSM: state, walk index, request edge register, deferred-start
  // flag, captured word and the registered stream/status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= IDX_ZERO;
      req_q_r     <= 1'b0;
      pending_r   <= 1'b0;
      dump_data_r <= {N{1'b0}};
      dump_addr_r <= IDX_ZERO;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      req_q_r <= dump_req;
      case (state_r)
        IDLE: begin
          idx_r  <= IDX_ZERO;
          done_r <= 1'b0;
          if (pending_r) begin
            // Request arrived alongside a CPU write last cycle; that write
            // has landed, so the walk can start now.
            pending_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= READ;
          end else if (req_rise_s && cpu_we) begin
            // Let the in-flight CPU write complete before taking the port.
            pending_r <= 1'b1;
          end else if (req_rise_s) begin
            busy_r  <= 1'b1;
            state_r <= READ;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          dump_data_r <= mem_rdata;
          dump_addr_r <= idx_r;
          valid_r     <= 1'b1;
          state_r     <= SEND;
        end
        SEND: begin
          if (dump_if.dump_ready) begin
            valid_r <= 1'b0;
            if (last_word_s) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              idx_r   <= idx_r + IDX_ONE;
              state_r <= READ;
            end
          end else begin
            state_r <= SEND;
          end
        end
        DONE: begin
          idx_r   <= IDX_ZERO;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          idx_r     <= IDX_ZERO;
          pending_r <= 1'b0;
          valid_r   <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Memory-port mux: the processor passes straight through in IDLE; in every
  // other state the walker owns the port and processor writes are dropped.
  always_comb begin
    cpu_rdata = {N{1'b0}};
    mem_addr  = idx_r;
    mem_wdata = {N{1'b0}};
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state_r)
      IDLE: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = cpu_re;
        cpu_rdata = mem_rdata;
      end
      READ: begin
        mem_re = 1'b1;
      end
      SEND, DONE: begin
        mem_re = 1'b0;
      end
      default: begin
        mem_re = 1'b0;
      end
    endcase
  end

  assign cpu_stall          = busy_r;
  assign dump_if.dump_valid = valid_r;
  assign dump_if.dump_addr  = dump_addr_r;
  assign dump_if.dump_data  = dump_data_r;
  assign dump_if.dump_busy  = busy_r;
  assign dump_if.dump_done  = done_r;

endmodule
